fp_op_arbiter: RTL and testbench



---
 rtl/fp_ctrl_pkg.sv | 32 +++
 rtl/rr_arbiter2.sv | 16 +
 rtl/fp_op_arbiter.sv | 158 +++++++++++++++
 tb/tb_fp_op_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_ctrl_pkg.sv
// Shared definitions for the FP datapath sharing logic: op codes, flag layout,
// canonical NaN and the arbiter FSM encoding.
package fp_ctrl_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_MUL  = 3'd2,
    OP_DIV  = 3'd3,
    OP_SQRT = 3'd4,
    OP_MIN  = 3'd5,
    OP_MAX  = 3'd6,
    OP_RSVD = 3'd7
  } fp_op_e;

  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam logic [31:0] CANON_QNAN = 32'h7FC0_0000;
  localparam logic [4:0]  FLAGS_NV   = 5'(1) << FLAG_NV;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } fp_state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: on a tie the requester that did not win last
// time gets the grant, otherwise whichever requester is valid.
module rr_arbiter2 (
  input  logic [1:0] i_valid,
  input  logic       i_last_grant,
  output logic       o_grant,
  output logic       o_any
);

  always_comb begin
    o_any = |i_valid;
    if (&i_valid) o_grant = ~i_last_grant;
    else          o_grant = i_valid[1];
  end

endmodule

// File: rtl/fp_op_arbiter.sv
// Shares one multi-cycle FP unit between two requesters: round-robin accept,
// start/done issue, response routed back to the owner, watchdog to canonical NaN.
module fp_op_arbiter
  import fp_ctrl_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int OP_W    = 3,
  parameter int FLAG_W  = 5,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [WIDTH-1:0]  req0_a,
  input  logic [WIDTH-1:0]  req0_b,

  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [WIDTH-1:0]  req1_a,
  input  logic [WIDTH-1:0]  req1_b,

  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [WIDTH-1:0]  rsp0_result,
  output logic [FLAG_W-1:0] rsp0_flags,

  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [WIDTH-1:0]  rsp1_result,
  output logic [FLAG_W-1:0] rsp1_flags,

  output logic              fpu_start,
  output logic [OP_W-1:0]   fpu_op,
  output logic [WIDTH-1:0]  fpu_a,
  output logic [WIDTH-1:0]  fpu_b,
  input  logic              fpu_done,
  input  logic [WIDTH-1:0]  fpu_result,
  input  logic [FLAG_W-1:0] fpu_flags,

  output logic              busy,
  output logic              timeout_err
);

  localparam int TW = $clog2(TIMEOUT) + 1;

  fp_state_e         r_state, w_next;
  logic              r_last_grant;
  logic              r_owner;
  logic [OP_W-1:0]   r_op;
  logic [WIDTH-1:0]  r_a, r_b;
  logic [WIDTH-1:0]  r_result;
  logic [FLAG_W-1:0] r_flags;
  logic [TW-1:0]     r_timer;
  logic              r_timeout_err;

  logic              w_grant, w_any, w_accept, w_rsvd, w_rsp_hs, w_timeout;
  logic [OP_W-1:0]   w_sel_op;
  logic [WIDTH-1:0]  w_sel_a, w_sel_b;

  rr_arbiter2 u_arb (
    .i_valid      ({req1_valid, req0_valid}),
    .i_last_grant (r_last_grant),
    .o_grant      (w_grant),
    .o_any        (w_any)
  );

  // Ready is only ever offered in IDLE and is masked while reset is asserted.
  assign w_accept   = (r_state == ST_IDLE) && w_any && !rst;
  assign req0_ready = w_accept && !w_grant;
  assign req1_ready = w_accept &&  w_grant;

  assign w_sel_op = w_grant ? req1_op : req0_op;
  assign w_sel_a  = w_grant ? req1_a  : req0_a;
  assign w_sel_b  = w_grant ? req1_b  : req0_b;
  assign w_rsvd   = (w_sel_op == OP_W'(OP_RSVD));

  assign w_rsp_hs  = (r_state == ST_RESP) && (r_owner ? rsp1_ready : rsp0_ready);
  // A done in the last allowed WAIT cycle still wins over the watchdog.
  assign w_timeout = (r_state == ST_WAIT) && !fpu_done && (r_timer == TW'(TIMEOUT - 1));

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_next = w_rsvd ? ST_RESP : ST_ISSUE;
      ST_ISSUE: w_next = ST_WAIT;
      ST_WAIT:  if (fpu_done || w_timeout) w_next = ST_RESP;
      ST_RESP:  if (w_rsp_hs) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant  <= 1'b1;
      r_owner       <= 1'b0;
      r_op          <= '0;
      r_a           <= '0;
      r_b           <= '0;
      r_result      <= '0;
      r_flags       <= '0;
      r_timer       <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      if (w_accept) begin
        r_owner      <= w_grant;
        r_last_grant <= w_grant;
        r_op         <= w_sel_op;
        r_a          <= w_sel_a;
        r_b          <= w_sel_b;
        if (w_rsvd) begin
          r_result <= WIDTH'(CANON_QNAN);
          r_flags  <= FLAG_W'(FLAGS_NV);
        end
      end

      if (r_state == ST_ISSUE)     r_timer <= '0;
      else if (r_state == ST_WAIT) r_timer <= r_timer + TW'(1);

      // Done is only honoured in WAIT; late or stray pulses fall through.
      if ((r_state == ST_WAIT) && fpu_done) begin
        r_result <= fpu_result;
        r_flags  <= fpu_flags;
      end else if (w_timeout) begin
        r_result      <= WIDTH'(CANON_QNAN);
        r_flags       <= FLAG_W'(FLAGS_NV);
        r_timeout_err <= 1'b1;
      end
    end
  end

  assign fpu_start   = (r_state == ST_ISSUE);
  assign fpu_op      = r_op;
  assign fpu_a       = r_a;
  assign fpu_b       = r_b;

  assign rsp0_valid  = (r_state == ST_RESP) && !r_owner;
  assign rsp1_valid  = (r_state == ST_RESP) &&  r_owner;
  assign rsp0_result = r_result;
  assign rsp1_result = r_result;
  assign rsp0_flags  = r_flags;
  assign rsp1_flags  = r_flags;

  assign busy        = (r_state != ST_IDLE);
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_fp_op_arbiter.sv
// Randomized and directed bench for fp_op_arbiter against a transaction-level
// timing model (accept cycle, FPU latency, response cycle) kept in the bench.
module tb_fp_op_arbiter;

  localparam int T = 8;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam logic [4:0]  NV   = 5'b10000;

  logic clk = 1'b0;
  logic rst;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0]  req0_op, req1_op, fpu_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp0_result, rsp1_result;
  logic [4:0]  rsp0_flags, rsp1_flags;
  logic fpu_start, fpu_done, busy, timeout_err;
  logic [31:0] fpu_a, fpu_b, fpu_result;
  logic [4:0]  fpu_flags;

  always #5 clk = ~clk;

  fp_op_arbiter #(.WIDTH(32), .OP_W(3), .FLAG_W(5), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_flags(rsp0_flags),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_flags(rsp1_flags),
    .fpu_start(fpu_start), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_done(fpu_done), .fpu_result(fpu_result), .fpu_flags(fpu_flags),
    .busy(busy), .timeout_err(timeout_err)
  );

  int n_cmp = 0, n_mis = 0, cyc = 0;

  // stimulus controls
  bit s_rst, s_rand, s_fix;
  int s_lat;
  logic [31:0] s_dres;
  logic [4:0]  s_dflg;
  logic [1:0]  s_rr;
  int s_left[2];
  bit p[2];
  logic [2:0]  p_op[2];
  logic [31:0] p_a[2], p_b[2];

  // model state
  bit m_known, m_busy, m_owner, m_last, m_to, m_terr, m_after_rst;
  logic [2:0]  m_op;
  logic [31:0] m_a, m_b, m_res, m_dres;
  logic [4:0]  m_flg, m_dflg;
  int m_acc, m_resp, m_done = -1;
  int n_acc = 0, n_start = 0;
  int glog[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  task automatic post(input int g, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    p[g] = 1'b1; p_op[g] = op; p_a[g] = a; p_b[g] = b;
  endtask

  task automatic step();
    bit g, ww, er0, er1, ersp;
    int L;
    @(posedge clk); #1;
    cyc++;
    for (int i = 0; i < 2; i++) if (!p[i]) begin
      if (s_left[i] > 0) begin
        s_left[i]--;
        post(i, 3'($urandom_range(0, 6)), $urandom, $urandom);
      end else if (s_rand && $urandom_range(0, 2) == 0) begin
        post(i, ($urandom_range(0, 7) == 0) ? 3'd7 : 3'($urandom_range(0, 6)), $urandom, $urandom);
      end
    end
    if (s_rand) begin
      s_rr[0] = ($urandom_range(0, 3) != 0);
      s_rr[1] = ($urandom_range(0, 3) != 0);
    end
    rst = s_rst;
    req0_valid = p[0]; req0_op = p_op[0]; req0_a = p_a[0]; req0_b = p_b[0];
    req1_valid = p[1]; req1_op = p_op[1]; req1_a = p_a[1]; req1_b = p_b[1];
    rsp0_ready = s_rr[0]; rsp1_ready = s_rr[1];
    ww = m_busy && (m_op != 3'd7) && (cyc >= m_acc + 2) && (cyc < m_resp);
    if (cyc == m_done) begin
      fpu_done = 1'b1; fpu_result = m_dres; fpu_flags = m_dflg;
    end else begin
      fpu_done = !ww && ($urandom_range(0, 7) == 0);
      fpu_result = $urandom; fpu_flags = 5'($urandom);
    end

    @(negedge clk);
    if (fpu_start === 1'b1) n_start++;
    g = (p[0] && p[1]) ? !m_last : p[1];
    if (m_known) begin
      er0  = !s_rst && !m_busy && p[0] && !g;
      er1  = !s_rst && !m_busy && p[1] &&  g;
      ersp = m_busy && (cyc >= m_resp);
      chk("req0_ready", req0_ready, er0);
      chk("req1_ready", req1_ready, er1);
      chk("fpu_start", fpu_start, m_busy && (m_op != 3'd7) && (cyc == m_acc + 1));
      chk("fpu_op", fpu_op, m_op);
      chk("fpu_a", fpu_a, m_a);
      chk("fpu_b", fpu_b, m_b);
      chk("rsp0_valid", rsp0_valid, ersp && !m_owner);
      chk("rsp1_valid", rsp1_valid, ersp && m_owner);
      if (ersp && !m_owner) begin
        chk("rsp0_result", rsp0_result, m_res); chk("rsp0_flags", rsp0_flags, m_flg);
      end
      if (ersp && m_owner) begin
        chk("rsp1_result", rsp1_result, m_res); chk("rsp1_flags", rsp1_flags, m_flg);
      end
      if (m_after_rst) begin
        chk("rst_rsp0_result", rsp0_result, 0); chk("rst_rsp1_flags", rsp1_flags, 0);
      end
      chk("busy", busy, m_busy);
      chk("timeout_err", timeout_err, m_terr || (m_busy && m_to && cyc >= m_resp));
    end

    if (s_rst) begin
      m_known = 1; m_busy = 0; m_last = 1; m_owner = 0; m_op = 0; m_a = 0; m_b = 0;
      m_res = 0; m_flg = 0; m_terr = 0; m_to = 0; m_after_rst = 1;
    end else if (m_known) begin
      m_after_rst = 0;
      if (m_busy) begin
        if (cyc >= m_resp && s_rr[m_owner]) begin
          m_busy = 0;
          if (m_to) m_terr = 1;
        end
      end else if (p[0] || p[1]) begin
        m_busy = 1; m_owner = g; m_last = g; m_op = p_op[g]; m_a = p_a[g]; m_b = p_b[g];
        m_acc = cyc; p[g] = 0; n_acc++; glog.push_back(int'(g)); m_to = 0;
        if (m_op == 3'd7) begin
          m_resp = cyc + 1; m_res = QNAN; m_flg = NV;
        end else begin
          if (s_rand) L = ($urandom_range(0, 4) == 0) ? $urandom_range(T - 1, T + 2) : $urandom_range(1, 4);
          else        L = (s_lat > 0) ? s_lat : $urandom_range(1, 5);
          m_done = cyc + 1 + L;
          m_dres = s_fix ? s_dres : $urandom;
          m_dflg = s_fix ? s_dflg : 5'($urandom);
          if (L <= T) begin
            m_resp = m_done + 1; m_res = m_dres; m_flg = m_dflg;
          end else begin
            m_resp = cyc + 2 + T; m_res = QNAN; m_flg = NV; m_to = 1;
          end
        end
      end
    end
  endtask

  task automatic wait_acc(output int acyc);
    int n0, k;
    n0 = n_acc; k = 0;
    while (n_acc == n0 && k < 60) begin step(); k++; end
    if (n_acc == n0) chk("accept_bound", 0, 1);
    acyc = m_acc;
  endtask

  task automatic wait_rsp(input bit w, output int rcyc);
    int k;
    k = 0;
    while ((w ? rsp1_valid : rsp0_valid) !== 1'b1 && k < 60) begin step(); k++; end
    if (k >= 60) chk("rsp_bound", 0, 1);
    rcyc = cyc;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((m_busy || p[0] || p[1] || s_left[0] > 0 || s_left[1] > 0) && k < 400) begin step(); k++; end
    if (k >= 400) chk("drain_bound", 0, 1);
    step();
  endtask

  task automatic scen_add();
    int a, r, ns;
    s_fix = 1; s_lat = 3; s_dres = 32'h40400000; s_dflg = 5'b0; s_rr = 2'b11;
    post(0, 3'd0, 32'h3F800000, 32'h40000000);
    wait_acc(a);
    ns = n_start;
    step();
    chk("s1_start_after_accept", fpu_start, 1);
    wait_rsp(0, r);
    chk("s1_rsp_latency", r - a, 5);
    chk("s1_result", rsp0_result, 32'h40400000);
    chk("s1_flags", rsp0_flags, 5'b00000);
    drain();
    chk("s1_start_count", n_start - ns, 1);
  endtask

  initial begin
    int a, r, ns, gbits;
    rst = 1; req0_valid = 0; req1_valid = 0; req0_op = 0; req1_op = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0; rsp0_ready = 0; rsp1_ready = 0;
    fpu_done = 0; fpu_result = 0; fpu_flags = 0;
    s_rst = 1; s_rand = 0; s_fix = 0; s_lat = -1; s_rr = 2'b11; s_left[0] = 0; s_left[1] = 0;
    // valids held high through reset: ready must stay low
    post(0, 3'd1, $urandom, $urandom);
    post(1, 3'd2, $urandom, $urandom);
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_fpu_a", fpu_a, 0);

    // both requesters busy with 4 ops each: strict alternation from requester 0
    glog.delete(); ns = n_start;
    s_rst = 0; s_left[0] = 3; s_left[1] = 3;
    drain();
    gbits = 0;
    foreach (glog[i]) gbits = gbits | (glog[i] << i);
    chk("s2_grant_count", glog.size(), 8);
    chk("s2_grant_order", gbits, 32'hAA);
    chk("s2_start_count", n_start - ns, 8);

    scen_add();

    // reserved op answered directly
    ns = n_start;
    post(1, 3'd7, 32'h11111111, 32'h22222222);
    wait_acc(a);
    step();
    chk("s4_rsp1_valid", rsp1_valid, 1);
    chk("s4_result", rsp1_result, 32'h7FC00000);
    chk("s4_flags", rsp1_flags, 5'b10000);
    chk("s4_terr", timeout_err, 0);
    drain();
    chk("s4_no_start", n_start - ns, 0);

    // response back-pressure
    s_fix = 1; s_lat = 2; s_dres = 32'h12345678; s_dflg = 5'b00101; s_rr = 2'b10;
    post(0, 3'd2, $urandom, $urandom);
    wait_acc(a);
    post(1, 3'd0, $urandom, $urandom);
    wait_rsp(0, r);
    ns = n_start;
    repeat (5) begin
      step();
      chk("s5_result_held", rsp0_result, 32'h12345678);
      chk("s5_flags_held", rsp0_flags, 5'b00101);
      chk("s5_req1_ready", req1_ready, 0);
      chk("s5_busy", busy, 1);
    end
    chk("s5_no_start", n_start - ns, 0);
    s_rr = 2'b11;
    drain();

    // watchdog: done never lands inside the window
    s_lat = T + 2;
    post(0, 3'd3, $urandom, $urandom);
    wait_acc(a);
    wait_rsp(0, r);
    chk("s3_rsp_latency", r - a, 2 + T);
    chk("s3_result", rsp0_result, 32'h7FC00000);
    chk("s3_flags", rsp0_flags, 5'b10000);
    chk("s3_terr", timeout_err, 1);
    drain();
    s_lat = 2;
    post(1, 3'd0, $urandom, $urandom);
    drain();
    chk("s3_terr_sticky", timeout_err, 1);

    // random traffic
    s_fix = 0; s_lat = -1; s_rand = 1;
    repeat (1500) step();
    s_rand = 0; s_rr = 2'b11;
    drain();

    // reset in WAIT; the abandoned op's done arrives two cycles later
    s_fix = 0; s_lat = 6;
    post(0, 3'd0, $urandom, $urandom);
    wait_acc(a);
    repeat (4) step();
    s_rst = 1; step(); s_rst = 0;
    repeat (4) step();
    chk("s6_no_rsp0", rsp0_valid, 0);
    chk("s6_busy", busy, 0);
    chk("s6_terr", timeout_err, 0);
    scen_add();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
